// File: rtl/uart_fifo_if.sv
// uart_fifo_if: push/pop handshake, occupancy and error-flag bundle for uart_fifo.
// The producer/consumer side uses the master modport; the FIFO uses the slave modport.
interface uart_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  i_wr;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  o_full;
    logic                  i_rd;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_empty;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_overflow;
    logic                  o_underflow;
    logic                  i_clr_err;

    modport master (
        output i_wr, i_wr_data, i_rd, i_clr_err,
        input  o_full, o_rd_data, o_empty, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_wr, i_wr_data, i_rd, i_clr_err,
        output o_full, o_rd_data, o_empty, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: circular-buffer FIFO between the UART and the operand/result FSMs.
// Registered read data (one cycle latency), occupancy count and sticky
// overflow/underflow flags. Full/empty decode only from the registered count.
module uart_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input logic        i_clock,
    input logic        i_reset,
    uart_fifo_if.slave bus
);
    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  overflow;
    logic                  underflow;
    logic                  empty;
    logic                  full;
    logic                  pop_ok;
    logic                  push_ok;

    // Status decode and accept logic; a pop on a full FIFO frees the slot the push uses.
    always_comb begin
        empty   = (count == '0);
        full    = (count == DEPTH_CNT);
        pop_ok  = bus.i_rd && !empty;
        push_ok = bus.i_wr && (!full || pop_ok);
    end

    // Storage array; contents are not reset.
    always_ff @(posedge i_clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.i_wr_data;
        end
    end

    // Pointers, occupancy, registered read data and sticky error flags.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
                rd_data <= mem[rd_ptr];
            end
            if (push_ok && !pop_ok) begin
                count <= count + (ADDR_WIDTH + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (ADDR_WIDTH + 1)'(1);
            end
            // a new error in the same cycle as a clear keeps the flag set
            if (bus.i_wr && !push_ok) begin
                overflow <= 1'b1;
            end else if (bus.i_clr_err) begin
                overflow <= 1'b0;
            end
            if (bus.i_rd && !pop_ok) begin
                underflow <= 1'b1;
            end else if (bus.i_clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.o_empty     = empty;
        bus.o_full      = full;
        bus.o_count     = count;
        bus.o_rd_data   = rd_data;
        bus.o_overflow  = overflow;
        bus.o_underflow = underflow;
    end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed + random stimulus against a queue-based reference model,
// with a scoreboard of expected popped words checked by an independent monitor.
module tb_uart_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;

    uart_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit [7:0] model_q[$];
    bit [7:0] exp_q[$];
    bit [7:0] m_rd;
    bit       m_ovf;
    bit       m_unf;
    bit       fire;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        chk("count",     32'(bus.o_count), 32'(model_q.size()));
        chk("empty",     32'(bus.o_empty), 32'(model_q.size() == 0));
        chk("full",      32'(bus.o_full),  32'(model_q.size() == DEPTH));
        chk("overflow",  32'(bus.o_overflow),  32'(m_ovf));
        chk("underflow", 32'(bus.o_underflow), 32'(m_unf));
        chk("rd_data",   32'(bus.o_rd_data),   32'(m_rd));
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its own queue.
    task automatic step(input bit wr, input bit [7:0] d, input bit rd, input bit clr);
        bit pop_ok;
        bit push_ok;
        bus.i_wr      = wr;
        bus.i_wr_data = d;
        bus.i_rd      = rd;
        bus.i_clr_err = clr;
        @(posedge clk);
        pop_ok  = rd && (model_q.size() > 0);
        push_ok = wr && ((model_q.size() < DEPTH) || pop_ok);
        if (pop_ok) begin
            m_rd = model_q.pop_front();
            exp_q.push_back(m_rd);
        end
        if (push_ok) model_q.push_back(d);
        if (wr && !push_ok) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (rd && !pop_ok)  m_unf = 1'b1;
        else if (clr)       m_unf = 1'b0;
        @(negedge clk);
        check_status();
    endtask

    task automatic model_reset();
        model_q.delete();
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Monitor: a pop handshake seen at the edge means o_rd_data is presented afterwards.
    always @(posedge clk) begin
        fire = rst && bus.i_rd && !bus.o_empty;
        @(negedge clk);
        if (fire) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no pop", bus.o_rd_data);
            end else begin
                chk("scoreboard_rd", 32'(bus.o_rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst           = 1'b0;
        bus.i_wr      = 1'b0;
        bus.i_wr_data = '0;
        bus.i_rd      = 1'b0;
        bus.i_clr_err = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0);

        // 2: three pushes, three spaced pops
        step(1, 8'h05, 0, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'h01, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1, 0);
            step(0, 8'h00, 0, 0);
        end

        // 3: fill, overflow, drain
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0);
        step(1, 8'hAA, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // 4: simultaneous push+pop while full
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0);
        step(1, 8'h77, 1, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
        chk("last_word_0x77", 32'(bus.o_rd_data), 32'h77);

        // 5: underflow, push+pop on empty, then clear (with new error colliding once)
        step(0, 8'h00, 1, 0);
        step(1, 8'h42, 1, 0);
        step(1, 8'h00, 0, 0);
        for (int i = 0; i < 14; i++) step(1, 8'(i), 0, 0);
        step(1, 8'h99, 0, 1);
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // 6a: 40 push/pop pairs through the wrap
        step(1, 8'h80, 0, 0);
        for (int i = 1; i <= 40; i++) step(1, 8'(8'h80 + i), 1, 0);
        step(0, 8'h00, 1, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 5));
        end

        // 6b: asynchronous reset between edges
        for (int i = 0; i < 6; i++) step(1, 8'($urandom), 0, 0);
        step(1, 8'hC3, 1, 0);
        #2;
        rst = 1'b0;
        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
        #1;
        model_reset();
        check_status();
        @(negedge clk);
        rst = 1'b1;
        step(0, 8'h00, 0, 0);
        step(1, 8'h5A, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
